// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the memory self-test block (mem_bist) and its
// compare/error-capture sub-module (mem_bist_chk).
//   bist_state_t : sequencer states
//   CTRL_*       : encodings of the 2-bit ctrlMEM request ([1]=read, [0]=write)
//   ERR_W        : width of the saturating mismatch counter
//   bist_pattern : test data for a given pass and byte address
// ---------------------------------------------------------------------------
package mem_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WR    = 3'd1,
      RD    = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } bist_state_t;

   localparam logic [1:0] CTRL_NONE = 2'b00;
   localparam logic [1:0] CTRL_WR   = 2'b01;
   localparam logic [1:0] CTRL_RD   = 2'b10;

   localparam int ERR_W = 16;

   // Pass 0 writes (addr ^ key); pass 1 writes its complement, so every cell
   // bit is exercised at both polarities across the two passes.
   function automatic logic [31:0] bist_pattern(input logic        pass,
                                                input logic [31:0] addr,
                                                input logic [31:0] key);
      logic [31:0] w_true;
      w_true = addr ^ key;
      return pass ? ~w_true : w_true;
   endfunction

endpackage

// File: rtl/mem_bist_chk.sv
// ---------------------------------------------------------------------------
// mem_bist_chk
// Read-compare pipeline for the memory self-test. Each issued read registers
// (valid, addr, expected); on the following posedge the memory's read data
// (updated on the intervening negedge) is compared. Mismatches increment a
// saturating counter; the first mismatch since the last clear also latches
// its address and the data actually read.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_clear             clears the counter and first-error capture
//   i_issue_valid       a read is being issued this cycle
//   i_issue_addr        byte address of that read
//   i_issue_exp         data the read is expected to return
//   i_readData          memory read data
//   o_errCount          saturating mismatch count
//   o_firstErrAddr      address of first mismatch
//   o_firstErrData      read data captured at first mismatch
// ---------------------------------------------------------------------------
module mem_bist_chk
   import mem_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_issue_valid,
   input  logic [31:0]      i_issue_addr,
   input  logic [31:0]      i_issue_exp,
   input  logic [31:0]      i_readData,
   output logic [ERR_W-1:0] o_errCount,
   output logic [31:0]      o_firstErrAddr,
   output logic [31:0]      o_firstErrData
);

   logic             r_cmp_valid;
   logic [31:0]      r_cmp_addr;
   logic [31:0]      r_cmp_exp;
   logic [ERR_W-1:0] r_err_count;
   logic             r_have_err;
   logic [31:0]      r_first_addr;
   logic [31:0]      r_first_data;
   logic             w_miss;

   assign w_miss = r_cmp_valid && (i_readData != r_cmp_exp);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would make results order-dependent.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cmp_valid  <= 1'b0;
         r_cmp_addr   <= '0;
         r_cmp_exp    <= '0;
         r_err_count  <= '0;
         r_have_err   <= 1'b0;
         r_first_addr <= '0;
         r_first_data <= '0;
      end else begin
         r_cmp_valid <= i_issue_valid;
         r_cmp_addr  <= i_issue_addr;
         r_cmp_exp   <= i_issue_exp;
         if (i_clear) begin
            r_err_count  <= '0;
            r_have_err   <= 1'b0;
            r_first_addr <= '0;
            r_first_data <= '0;
         end else if (w_miss) begin
            if (r_err_count != '1) begin
               r_err_count <= r_err_count + 1'b1;
            end
            // A separate flag (not count==0) marks the first error, so the
            // capture is independent of the counter's value.
            if (!r_have_err) begin
               r_have_err   <= 1'b1;
               r_first_addr <= r_cmp_addr;
               r_first_data <= i_readData;
            end
         end
      end
   end

   assign o_errCount     = r_err_count;
   assign o_firstErrAddr = r_first_addr;
   assign o_firstErrData = r_first_data;

endmodule

// File: rtl/mem_bist.sv
// ---------------------------------------------------------------------------
// mem_bist
// Memory self-test initiator. Replaces the pipeline MEM stage during test and
// drives the data-memory request interface. Two write-then-read-verify passes
// run over ADDR_WORDS words from BASE_ADDR: pass 0 with the true pattern,
// pass 1 with the inverted pattern. Reports error count and first failure.
// All request outputs are registered: each request is held posedge to posedge.
// Ports:
//   i_clk           clock
//   i_reset         synchronous active-high reset
//   i_start         start pulse, honoured in IDLE or DONE
//   i_abort         synchronous abort back to IDLE (errCount retained)
//   i_readData      memory read data (valid after the read-issue negedge)
//   o_memAddr       byte address to memory
//   o_writeData     write data to memory
//   o_ctrlMEM       [1]=read, [0]=write
//   o_busy          test in progress (WR/RD/DRAIN)
//   o_done          test finished (DONE)
//   o_pass          finished with zero mismatches
//   o_errCount      saturating mismatch count
//   o_firstErrAddr  address of first mismatch
//   o_firstErrData  data read at first mismatch
// ---------------------------------------------------------------------------
module mem_bist
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_WORDS = 2048,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter logic [31:0] PAT_XOR    = 32'hA5A5_5A5A
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_abort,
   input  logic [31:0] i_readData,
   output logic [31:0] o_memAddr,
   output logic [31:0] o_writeData,
   output logic [1:0]  o_ctrlMEM,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_pass,
   output logic [15:0] o_errCount,
   output logic [31:0] o_firstErrAddr,
   output logic [31:0] o_firstErrData
);

   localparam int               IDX_W    = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ADDR_WORDS - 1);

   bist_state_t      r_state, w_next_state;
   logic [IDX_W-1:0] r_idx, w_next_idx;
   logic             r_pass, w_next_pass;
   logic             w_clear;
   logic             w_last;

   logic [1:0]       r_ctrl, w_req_ctrl;
   logic [31:0]      r_addr, w_req_addr;
   logic [31:0]      r_wdata, w_req_wdata;
   logic             r_busy, r_done;
   logic [31:0]      w_word_addr;
   logic [31:0]      w_exp;
   logic             w_issue_valid;
   logic [15:0]      w_err_count;

   assign w_last = (r_idx == LAST_IDX);

   // r_idx always names the word whose request is currently on the outputs;
   // the next request is formed from the next-state values and registered.
   // NOTE: every always_comb output gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      w_next_idx   = r_idx;
      w_next_pass  = r_pass;
      w_clear      = 1'b0;

      if (i_abort) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (i_start) begin
                  w_clear      = 1'b1;
                  w_next_idx   = '0;
                  w_next_pass  = 1'b0;
                  w_next_state = WR;
               end
            end
            WR: begin
               if (w_last) begin
                  w_next_idx   = '0;
                  w_next_state = RD;
               end else begin
                  w_next_idx = r_idx + 1'b1;
               end
            end
            RD: begin
               if (w_last) begin
                  w_next_idx   = '0;
                  w_next_state = DRAIN;
               end else begin
                  w_next_idx = r_idx + 1'b1;
               end
            end
            DRAIN: begin
               // The last read of the pass is compared while in DRAIN.
               w_next_idx = '0;
               if (!r_pass) begin
                  w_next_pass  = 1'b1;
                  w_next_state = WR;
               end else begin
                  w_next_state = DONE;
               end
            end
            default: w_next_state = IDLE;
         endcase
      end
   end

   assign w_word_addr = BASE_ADDR + (32'(w_next_idx) << 2);
   assign w_exp       = bist_pattern(w_next_pass, w_word_addr, PAT_XOR);

   always_comb begin
      w_req_ctrl    = CTRL_NONE;
      w_req_addr    = '0;
      w_req_wdata   = '0;
      w_issue_valid = 1'b0;
      case (w_next_state)
         WR: begin
            w_req_ctrl  = CTRL_WR;
            w_req_addr  = w_word_addr;
            w_req_wdata = w_exp;
         end
         RD: begin
            w_req_ctrl    = CTRL_RD;
            w_req_addr    = w_word_addr;
            w_issue_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_pass  <= 1'b0;
         r_ctrl  <= CTRL_NONE;
         r_addr  <= '0;
         r_wdata <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_idx   <= w_next_idx;
         r_pass  <= w_next_pass;
         r_ctrl  <= w_req_ctrl;
         r_addr  <= w_req_addr;
         r_wdata <= w_req_wdata;
         r_busy  <= (w_next_state == WR) || (w_next_state == RD) ||
                    (w_next_state == DRAIN);
         r_done  <= (w_next_state == DONE);
      end
   end

   mem_bist_chk u_chk (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_clear        (w_clear),
      .i_issue_valid  (w_issue_valid),
      .i_issue_addr   (w_req_addr),
      .i_issue_exp    (w_exp),
      .i_readData     (i_readData),
      .o_errCount     (w_err_count),
      .o_firstErrAddr (o_firstErrAddr),
      .o_firstErrData (o_firstErrData)
   );

   assign o_memAddr   = r_addr;
   assign o_writeData = r_wdata;
   assign o_ctrlMEM   = r_ctrl;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   // The count is stable throughout DONE, so this is glitch-free in practice.
   assign o_pass      = r_done && (w_err_count == '0);
   assign o_errCount  = w_err_count;

endmodule
